// File: rtl/register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_pkg
//  Description : Shared defaults and helpers for the register_pipe slice.
//                REG_DEFAULT_WIDTH / REG_DEFAULT_DEPTH give the historical
//                64-bit, two-stage configuration; occ_width() sizes the
//                occupancy counter so it can represent 0..depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_pkg;

    localparam int REG_DEFAULT_WIDTH = 64;
    localparam int REG_DEFAULT_DEPTH = 2;

    // Bits needed to count from 0 up to and including depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : register_pipe_stage
//  Description : One pipe stage: a WIDTH-bit data register plus its valid bit.
//  Ports       : clk     - rising-edge clock
//                rst     - asynchronous active-high reset (data and valid -> 0)
//                i_load  - capture i_d and mark the stage valid
//                i_clear - mark the stage empty (data register untouched)
//                i_d     - incoming data word
//                o_q     - stored data word
//                o_v     - stage valid bit
//  Revision    : 1.0 - initial release
// ============================================================================
module register_pipe_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_v
);

    logic [WIDTH-1:0] r_data;
    logic             r_v;

    // Clear wins over load for the valid bit; the parent never asserts both
    // in the same cycle, but the priority keeps a flush authoritative.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_v    <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_d;
            end
            if (i_clear) begin
                r_v <= 1'b0;
            end else if (i_load) begin
                r_v <= 1'b1;
            end
        end
    end

    assign o_q = r_data;
    assign o_v = r_v;

endmodule
`default_nettype wire

// File: rtl/register_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : register_pipe
//  Description : DEPTH-stage registered pipe with valid/ready handshakes at
//                both ends, bubble collapse, synchronous flush and an
//                occupancy count. Stage 0 is the input side, stage DEPTH-1
//                drives output_latch.
//  Ports       : clk          - rising-edge clock
//                rst          - asynchronous active-high reset
//                flush        - synchronous clear of all stage valid bits
//                in_valid     - upstream presents input_port
//                in_ready     - pipe accepts input_port this cycle
//                input_port   - data in (raw bits)
//                out_valid    - output_latch holds a valid word
//                out_ready    - downstream consumes output_latch this cycle
//                output_latch - registered last-stage data
//                occupancy    - number of valid stages, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module register_pipe
    import register_pkg::*;
#(
    parameter int WIDTH = REG_DEFAULT_WIDTH,
    parameter int DEPTH = REG_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              input_port,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              output_latch,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int                c_OCC_W   = occ_width(DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

    logic [WIDTH-1:0]   w_data [DEPTH];
    logic [DEPTH-1:0]   w_v;
    logic [DEPTH-1:0]   w_move;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_OCC_W-1:0] r_occ;

    // Ready chain, evaluated from the output end backwards: a stage empties
    // this cycle if its successor is empty or is itself emptying. This is a
    // purely combinational path from out_ready to in_ready.
    always_comb begin
        w_move          = '0;
        w_move[DEPTH-1] = w_v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_move[i] = w_v[i] & (~w_v[i+1] | w_move[i+1]);
        end
    end

    // No handshake may complete while reset is held.
    assign in_ready   = ~rst & ~flush & (~w_v[0] | w_move[0]);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_v[DEPTH-1] & out_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_load;
        logic [WIDTH-1:0] w_d;

        if (gi == 0) begin : g_head
            assign w_load = w_in_xfer;
            assign w_d    = input_port;
        end else begin : g_link
            // Loads are suppressed on flush so data registers keep their values.
            assign w_load = w_move[gi-1] & ~flush;
            assign w_d    = w_data[gi-1];
        end

        register_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_clear (flush | (w_move[gi] & ~w_load)),
            .i_d     (w_d),
            .o_q     (w_data[gi]),
            .o_v     (w_v[gi])
        );
    end

    // Tracks popcount(w_v) incrementally from the two handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign out_valid    = w_v[DEPTH-1];
    assign output_latch = w_data[DEPTH-1];
    assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_register_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_pipe
//  Description : Self-checking bench for register_pipe. Directed vector table
//                and hand sequences on a DEPTH=2 instance; scoreboarded
//                random traffic on DEPTH=1 and DEPTH=5 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        fl2 = 1'b0, iv2 = 1'b0, or2 = 1'b0;
    logic [63:0] din2 = '0;
    logic        ir2, ov2;
    logic [63:0] out2;
    logic [1:0]  occ2;

    // DEPTH=1 and DEPTH=5 instances
    logic        fl_off = 1'b0;
    logic        iv1 = 1'b0, or1 = 1'b0, iv5 = 1'b0, or5 = 1'b0;
    logic [63:0] din1 = '0, din5 = '0;
    logic        ir1, ov1, ir5, ov5;
    logic [63:0] out1, out5;
    logic [0:0]  occ1;
    logic [2:0]  occ5;

    register_pipe #(.WIDTH(64), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
        .input_port(din2), .out_valid(ov2), .out_ready(or2),
        .output_latch(out2), .occupancy(occ2));

    register_pipe #(.WIDTH(64), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(fl_off), .in_valid(iv1), .in_ready(ir1),
        .input_port(din1), .out_valid(ov1), .out_ready(or1),
        .output_latch(out1), .occupancy(occ1));

    register_pipe #(.WIDTH(64), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .flush(fl_off), .in_valid(iv5), .in_ready(ir5),
        .input_port(din5), .out_valid(ov5), .out_ready(or5),
        .output_latch(out5), .occupancy(occ5));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        iv, orr, fl;
        logic [63:0] din;
        logic        ir, ov;
        logic [63:0] dout;
        logic [1:0]  occ;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic orr, input logic fl,
                                input logic [63:0] din, input logic ir, input logic ov,
                                input logic [63:0] dout, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.orr = orr; v.fl = fl; v.din = din;
        v.ir = ir; v.ov = ov; v.dout = dout; v.occ = occ;
        return v;
    endfunction

    typedef struct {
        logic [63:0] d;
        int          t;
    } sb_t;

    sb_t  q1[$];
    sb_t  q5[$];
    vec_t vecs[20];

    initial begin
        // Expected values are the pre-edge state observed mid-cycle.
        //             iv or fl din                        ir ov dout                  occ
        vecs[0]  = mk(1, 1, 0, 64'hDB6D_B6DB_6DB6_DB6D, 1, 0, 64'h0,                 2'd0);
        vecs[1]  = mk(1, 1, 0, 64'h1,                   1, 0, 64'h0,                 2'd1);
        vecs[2]  = mk(1, 1, 0, 64'h2,                   1, 1, 64'hDB6D_B6DB_6DB6_DB6D, 2'd2);
        vecs[3]  = mk(0, 1, 0, 64'h0,                   1, 1, 64'h1,                 2'd2);
        vecs[4]  = mk(0, 1, 0, 64'h0,                   1, 1, 64'h2,                 2'd1);
        vecs[5]  = mk(0, 0, 0, 64'h0,                   1, 0, 64'h2,                 2'd0);
        vecs[6]  = mk(1, 0, 0, 64'hA,                   1, 0, 64'h2,                 2'd0);
        vecs[7]  = mk(1, 0, 0, 64'hB,                   1, 0, 64'h2,                 2'd1);
        vecs[8]  = mk(1, 0, 0, 64'hC,                   0, 1, 64'hA,                 2'd2);
        vecs[9]  = mk(1, 0, 0, 64'hC,                   0, 1, 64'hA,                 2'd2);
        vecs[10] = mk(1, 1, 0, 64'hC,                   1, 1, 64'hA,                 2'd2);
        vecs[11] = mk(1, 1, 0, 64'hD,                   1, 1, 64'hB,                 2'd2);
        vecs[12] = mk(0, 1, 0, 64'h0,                   1, 1, 64'hC,                 2'd2);
        vecs[13] = mk(0, 1, 0, 64'h0,                   1, 1, 64'hD,                 2'd1);
        vecs[14] = mk(0, 0, 0, 64'h0,                   1, 0, 64'hD,                 2'd0);
        vecs[15] = mk(1, 0, 0, 64'hE,                   1, 0, 64'hD,                 2'd0);
        vecs[16] = mk(1, 0, 0, 64'hF,                   1, 0, 64'hD,                 2'd1);
        vecs[17] = mk(1, 0, 1, 64'h77,                  0, 1, 64'hE,                 2'd2);
        vecs[18] = mk(0, 0, 0, 64'h0,                   1, 0, 64'hE,                 2'd0);
        vecs[19] = mk(0, 1, 0, 64'h0,                   1, 0, 64'hE,                 2'd0);

        // Reset state
        @(negedge clk); #1;
        check("reset out_valid", {63'd0, ov2}, 64'd0);
        check("reset output_latch", out2, 64'd0);
        check("reset occupancy", {62'd0, occ2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset", {63'd0, ir2}, 64'd1);

        // Directed table: stream, backpressure, flush
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            iv2 = vecs[k].iv; or2 = vecs[k].orr; fl2 = vecs[k].fl; din2 = vecs[k].din;
            #1;
            check($sformatf("vec%0d in_ready", k), {63'd0, ir2}, {63'd0, vecs[k].ir});
            check($sformatf("vec%0d out_valid", k), {63'd0, ov2}, {63'd0, vecs[k].ov});
            check($sformatf("vec%0d output_latch", k), out2, vecs[k].dout);
            check($sformatf("vec%0d occupancy", k), {62'd0, occ2}, {62'd0, vecs[k].occ});
        end

        // Full pass-through: fill, then 10 cycles of simultaneous in/out
        @(negedge clk); iv2 = 1'b1; or2 = 1'b0; fl2 = 1'b0; din2 = 64'h100;
        @(negedge clk); din2 = 64'h101;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv2 = 1'b1; or2 = 1'b1; din2 = 64'h102 + 64'(k);
            #1;
            check($sformatf("pass%0d occupancy", k), {62'd0, occ2}, 64'd2);
            check($sformatf("pass%0d out_valid", k), {63'd0, ov2}, 64'd1);
            check($sformatf("pass%0d in_ready", k), {63'd0, ir2}, 64'd1);
            check($sformatf("pass%0d output_latch", k), out2, 64'h100 + 64'(k));
        end

        // Asynchronous reset between edges with the pipe full
        @(negedge clk); iv2 = 1'b0; or2 = 1'b0;
        #1;
        check("pre-reset occupancy", {62'd0, occ2}, 64'd2);
        check("pre-reset output_latch", out2, 64'h10A);
        #1 rst = 1'b1;
        #1;
        check("async reset out_valid", {63'd0, ov2}, 64'd0);
        check("async reset output_latch", out2, 64'd0);
        check("async reset occupancy", {62'd0, occ2}, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("post-reset in_ready", {63'd0, ir2}, 64'd1);

        // Random traffic with scoreboards on DEPTH=1 and DEPTH=5
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic e_ov1, e_ir1, e_ov5, e_ir5;
            @(negedge clk);
            iv1 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1));
            iv5 = 1'($urandom_range(0, 1)); or5 = ($urandom_range(0, 3) != 0);
            if (cyc >= 200 && cyc < 260) or5 = 1'b0;   // force fill / bubble collapse
            din1 = {$urandom, $urandom};
            din5 = {$urandom, $urandom};
            #1;
            // DEPTH=1
            e_ov1 = (q1.size() > 0) && (cyc - q1[0].t >= 1);
            e_ir1 = (q1.size() < 1) || or1;
            check("d1 occupancy", {63'd0, occ1}, 64'(q1.size()));
            check("d1 out_valid", {63'd0, ov1}, {63'd0, e_ov1});
            check("d1 in_ready", {63'd0, ir1}, {63'd0, e_ir1});
            if (e_ov1) begin
                check("d1 data", out1, q1[0].d);
                if (or1) void'(q1.pop_front());
            end
            if (iv1 && e_ir1) q1.push_back('{d: din1, t: cyc});
            // DEPTH=5
            e_ov5 = (q5.size() > 0) && (cyc - q5[0].t >= 5);
            e_ir5 = (q5.size() < 5) || or5;
            check("d5 occupancy", {61'd0, occ5}, 64'(q5.size()));
            check("d5 out_valid", {63'd0, ov5}, {63'd0, e_ov5});
            check("d5 in_ready", {63'd0, ir5}, {63'd0, e_ir5});
            if (e_ov5) begin
                check("d5 data", out5, q5[0].d);
                if (or5) void'(q5.pop_front());
            end
            if (iv5 && e_ir5) q5.push_back('{d: din5, t: cyc});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_pipe.md
# register_pipe

Parametrised successor to the single 64-bit `Register` latch. It is a chain of `DEPTH` registered stages, each `WIDTH` bits wide, with a valid/ready handshake at both ends. Bubbles collapse, the chain supports synchronous flush, and it reports an occupancy count. It sits on datapath boundaries where the plain latch is insufficient because downstream can stall.

## Interface
- `WIDTH`, 64, data width in bits (≥1)
- `DEPTH`, 2, number of register stages (≥1)
- `clk` input 1, rising-edge clock
- `rst` input 1, asynchronous active-high reset
- `flush` input 1, synchronous clear of all stage valid bits
- `in_valid` input 1, upstream presents `input_port`
- `in_ready` output 1, pipe accepts `input_port` this cycle
- `input_port` input `WIDTH`, data in; treated as raw bits, signedness preserved
- `out_valid` output 1, `output_latch` holds a valid word
- `out_ready` input 1, downstream consumes `output_latch` this cycle
- `output_latch` output `WIDTH`, registered last-stage data
- `occupancy` output `$clog2(DEPTH+1)`, number of valid stages, 0..`DEPTH`

## Operation
- Stages are numbered 0 (input side) to `DEPTH-1` (output side). Each stage holds `data[i]` and `v[i]`.
- Advance rule:
  - `adv[DEPTH-1] = v[DEPTH-1] & out_ready`.
  - For each `i`, stage `i` can load when `!v[i] | move[i]`, where `move[i]` means stage `i` is being emptied this cycle.
  - Stage `i` moves into stage `i+1` when `v[i] & (!v[i+1] | move[i+1])`.
- `in_ready = !flush & (!v[0] | move[0])`. This ready chain is combinational through all stages.
- A transfer in means `in_valid & in_ready`. A transfer out means `out_valid & out_ready`.
- `out_valid = v[DEPTH-1]` and `output_latch = data[DEPTH-1]`. No combinational path from `input_port` to `output_latch`.
- Data is never duplicated or dropped except on flush or reset. Order is strictly FIFO.
- Flush:
  - Next edge sets all `v[i]` to 0 and `occupancy` to 0.
  - Data registers keep their values.
  - Any `in_valid` in the flush cycle is not accepted, because `in_ready` is 0.
  - An `out_ready` in the flush cycle still completes that cycle's output transfer.
- `occupancy` is updated with the valid bits: `+1` on a transfer in, `-1` on a transfer out, unchanged when both occur. Its value always equals the popcount of `v`.
- `output_latch` holds its value while `out_valid` is 0. No X is ever driven after reset.

## Timing
- Reset (async assert, sync-safe deassert):
  - all `v` = 0 and all `data` = 0
  - `out_valid` = 0, `output_latch` = 0, `occupancy` = 0
  - `in_ready` = 1 as soon as `rst` falls, provided `flush` = 0
- Latency: a word accepted at edge N is visible on `output_latch` with `out_valid`=1 after edge N+`DEPTH-1`, i.e. `DEPTH` cycles after presentation, when there is no backpressure and the pipe starts empty.
- Throughput: one word per cycle sustained while `out_ready`=1.
- Full (`occupancy`=`DEPTH`) with `out_ready`=0: `in_ready`=0.
- Full with `out_ready`=1: `in_ready`=1, and the simultaneous transfer in and out keeps `occupancy` = `DEPTH`.
- Empty with `in_valid`=0: `out_valid`=0 and `output_latch` is stable.
- Bubble collapse: with downstream stalled, upstream words fill empty stages behind the head until the pipe is full.
- Reset mid-stream: all contents are lost immediately (asynchronously). No transfer is reported in the cycle `rst` is high.

## Structure
- `register_pkg` holds:
  - `REG_DEFAULT_WIDTH` = 64
  - `REG_DEFAULT_DEPTH` = 2
  - function `occ_width(depth)` = `$clog2(depth+1)`
- Sub-module `register_pipe_stage`: one `WIDTH` data register plus valid bit, with `load`/`clear` inputs, async `rst`. It is instantiated `DEPTH` times in a generate loop. The top level holds the ready chain and the occupancy counter.

## Test plan
- Reset then stream, `WIDTH`=64, `DEPTH`=2, `out_ready`=1, inputs 0xDB6DB6DB6DB6DB6D, 0x1, 0x2 on consecutive cycles → those values appear on consecutive cycles starting 2 cycles after the first presentation; `occupancy` peaks at 2.
- Backpressure: `out_ready`=0, present 4 words (0xA, 0xB, 0xC, 0xD) → A and B accepted, `in_ready`=0 while full, `occupancy`=2; release `out_ready` → output order A, B, C, D, with nothing lost or duplicated.
- Full pass-through: full pipe, `in_valid`=1, `out_ready`=1 for 10 cycles → `occupancy` stays 2 and one word leaves per cycle.
- Flush: `occupancy`=2 with `flush`=1 and `in_valid`=1 for one cycle → next cycle `out_valid`=0 and `occupancy`=0; the flush-cycle input is not accepted; `output_latch` retains its last value.
- Async reset mid-stream: assert `rst` between edges with the pipe full → `out_valid`, `output_latch` and `occupancy` go to 0 without a clock edge.
- `DEPTH`=1 and `DEPTH`=5, random `in_valid`/`out_ready` with a scoreboard → FIFO order holds, 1-cycle and 5-cycle minimum latency respectively, and `occupancy` always equals the popcount of the valid bits.
